// File: rtl/keypad_pkg.sv
// ============================================================================
// Module  : keypad_pkg
// Purpose : Shared FSM state encodings and key-code helpers for keypad_scanner
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

   localparam logic [1:0] ST_SCAN     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_HELD     = 2'd2;
   localparam logic [1:0] ST_RELEASE  = 2'd3;

   // 4x3 telephone layout: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #  (star=10, hash=11)
   function automatic logic [3:0] code_to_digit(input logic [3:0] code);
      logic [3:0] digit;
      case (code)
         4'd9:    digit = 4'd10;
         4'd10:   digit = 4'd0;
         4'd11:   digit = 4'd11;
         default: digit = code + 4'd1;
      endcase
      return digit;
   endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_tick_gen.sv
// ============================================================================
// Module  : scan_tick_gen
// Purpose : Free-running divider producing a one-clk scan tick every CLK_DIV clks
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_tick_gen #(
   parameter int CLK_DIV = 12500
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = $clog2(CLK_DIV);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module  : keypad_scanner
// Purpose : Matrix keypad scan, debounce, auto-repeat and valid/ready key events
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS         = 4,
   parameter int COLS         = 3,
   parameter int CLK_DIV      = 12500,
   parameter int DEBOUNCE     = 4,
   parameter int REPEAT_TICKS = 0,
   parameter int CODE_W       = $clog2(ROWS * COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROWS-1:0]   key_row,
   output logic [COLS-1:0]   key_col,
   output logic              ev_valid,
   output logic [CODE_W-1:0] ev_code,
   output logic              ev_repeat,
   input  logic              ev_ready,
   output logic              key_held,
   output logic              overrun
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = $clog2(COLS);
   localparam int DB_W  = $clog2(DEBOUNCE + 1);
   localparam int REP_W = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

   logic              tick;
   logic [1:0]        state, state_nxt;
   logic [COLS-1:0]   col_nxt;
   logic [COL_W-1:0]  col_idx, cidx_nxt;
   logic [ROW_W-1:0]  cap_row, crow_nxt;
   logic [DB_W-1:0]   deb_cnt, deb_nxt;
   logic [REP_W-1:0]  rep_cnt, rep_nxt;
   logic              held_nxt;
   logic              emit, emit_rep;
   logic              cap_bit;
   logic [CODE_W-1:0] code_nxt;

   scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   function automatic logic [ROW_W-1:0] lowest_row(input logic [ROWS-1:0] rows);
      logic [ROW_W-1:0] idx;
      idx = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (rows[i]) idx = ROW_W'(i);
      end
      return idx;
   endfunction

   // With key_col frozen on the captured column, the captured row bit is that key
   assign cap_bit  = key_row[cap_row];
   assign code_nxt = CODE_W'(int'(crow_nxt) * COLS + int'(cidx_nxt));

   always_comb begin
      state_nxt = state;
      col_nxt   = key_col;
      cidx_nxt  = col_idx;
      crow_nxt  = cap_row;
      deb_nxt   = deb_cnt;
      rep_nxt   = rep_cnt;
      held_nxt  = key_held;
      emit      = 1'b0;
      emit_rep  = 1'b0;
      if (tick) begin
         case (state)
            ST_SCAN: begin
               if (key_col == '0) begin
                  col_nxt  = COLS'(1);
                  cidx_nxt = '0;
               end else if (key_row == '0) begin
                  col_nxt  = {key_col[COLS-2:0], key_col[COLS-1]};
                  cidx_nxt = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
               end else begin
                  crow_nxt = lowest_row(key_row);
                  deb_nxt  = DB_W'(1);
                  if (DEBOUNCE == 1) begin
                     emit      = 1'b1;
                     held_nxt  = 1'b1;
                     rep_nxt   = '0;
                     state_nxt = ST_HELD;
                  end else begin
                     state_nxt = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (cap_bit) begin
                  deb_nxt = deb_cnt + DB_W'(1);
                  if (deb_nxt == DB_W'(DEBOUNCE)) begin
                     emit      = 1'b1;
                     held_nxt  = 1'b1;
                     rep_nxt   = '0;
                     state_nxt = ST_HELD;
                  end
               end else begin
                  deb_nxt   = '0;
                  state_nxt = ST_SCAN;
                  col_nxt   = {key_col[COLS-2:0], key_col[COLS-1]};
                  cidx_nxt  = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
               end
            end
            ST_HELD: begin
               if (!cap_bit) begin
                  deb_nxt = DB_W'(1);
                  if (DEBOUNCE == 1) begin
                     held_nxt  = 1'b0;
                     state_nxt = ST_SCAN;
                  end else begin
                     state_nxt = ST_RELEASE;
                  end
               end else if (REPEAT_TICKS > 0) begin
                  if (rep_cnt == REP_W'(REPEAT_TICKS - 1)) begin
                     rep_nxt  = '0;
                     emit     = 1'b1;
                     emit_rep = 1'b1;
                  end else begin
                     rep_nxt = rep_cnt + REP_W'(1);
                  end
               end
            end
            default: begin
               if (!cap_bit) begin
                  deb_nxt = deb_cnt + DB_W'(1);
                  if (deb_nxt == DB_W'(DEBOUNCE)) begin
                     held_nxt  = 1'b0;
                     state_nxt = ST_SCAN;
                  end
               end else begin
                  state_nxt = ST_HELD;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_SCAN;
         key_col  <= '0;
         col_idx  <= '0;
         cap_row  <= '0;
         deb_cnt  <= '0;
         rep_cnt  <= '0;
         key_held <= 1'b0;
      end else begin
         state    <= state_nxt;
         key_col  <= col_nxt;
         col_idx  <= cidx_nxt;
         cap_row  <= crow_nxt;
         deb_cnt  <= deb_nxt;
         rep_cnt  <= rep_nxt;
         key_held <= held_nxt;
      end
   end

   // A pending event is never overwritten unless it is accepted in the same clk
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ev_valid  <= 1'b0;
         ev_code   <= '0;
         ev_repeat <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (emit) begin
            if (!ev_valid || ev_ready) begin
               ev_valid  <= 1'b1;
               ev_code   <= code_nxt;
               ev_repeat <= emit_rep;
            end else begin
               overrun <= 1'b1;
            end
         end else if (ev_valid && ev_ready) begin
            ev_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire
